// File: rtl/vrot_pkg.sv
// Shared types for the vrot_pipe lane rotate/shift unit.
// VROT_ARITH_SHIFT_EN widens the op encoding to add SRA.
package vrot_pkg;

  localparam int VROT_NUM_LANES = 4;
  localparam int VROT_LANE_W    = 32;
  localparam int VROT_TAG_W     = 4;

`ifdef VROT_ARITH_SHIFT_EN
  typedef enum logic [2:0] {
    ROR = 3'd0,
    ROL = 3'd1,
    SRL = 3'd2,
    SLL = 3'd3,
    SRA = 3'd4
  } vrot_op_e;
`else
  typedef enum logic [1:0] {
    ROR = 2'd0,
    ROL = 2'd1,
    SRL = 2'd2,
    SLL = 2'd3
  } vrot_op_e;
`endif

  function automatic int vrot_amt_w(input int lane_w);
    return $clog2(lane_w);
  endfunction

  // One beat at the default geometry; amt keeps the full-width lane layout.
  typedef struct packed {
    logic [VROT_NUM_LANES*VROT_LANE_W-1:0] data;
    logic [VROT_NUM_LANES*VROT_LANE_W-1:0] amt;
    vrot_op_e                              op;
    logic [VROT_TAG_W-1:0]                 tag;
  } vrot_beat_t;

endpackage

// File: rtl/vrot_if.sv
// Valid/ready beat interface of vrot_pipe: producer-side and consumer-side signals.
interface vrot_if
  import vrot_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 32,
  parameter int TAG_W     = 4
);

  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_LANES*LANE_W-1:0] in_data;
  logic [NUM_LANES*LANE_W-1:0] in_amt;
  vrot_op_e                    in_op;
  logic [TAG_W-1:0]            in_tag;
  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_LANES*LANE_W-1:0] out_data;
  logic [TAG_W-1:0]            out_tag;

  modport master (
    output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/vrot_stage.sv
// One log-shifter stage: moves every lane by SHIFT when its amount bit is set,
// and holds the beat with a valid bit under bubble-collapsing load control.
module vrot_stage
  import vrot_pkg::*;
#(
  parameter int SHIFT     = 1,
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 32,
  parameter int TAG_W     = 4,
  localparam int AMT_W    = vrot_amt_w(LANE_W)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [NUM_LANES*LANE_W-1:0] in_data,
  input  logic [NUM_LANES*AMT_W-1:0]  in_amt,
  input  vrot_op_e                    in_op,
  input  logic [TAG_W-1:0]            in_tag,
  input  logic                        nxt_load,
  output logic                        load,
  output logic                        out_valid,
  output logic [NUM_LANES*LANE_W-1:0] out_data,
  output logic [NUM_LANES*AMT_W-1:0]  out_amt,
  output vrot_op_e                    out_op,
  output logic [TAG_W-1:0]            out_tag
);

  localparam int K = $clog2(SHIFT);

  logic                        valid_r;
  logic [NUM_LANES*LANE_W-1:0] data_r;
  logic [NUM_LANES*AMT_W-1:0]  amt_r;
  vrot_op_e                    op_r;
  logic [TAG_W-1:0]            tag_r;
  logic [NUM_LANES*LANE_W-1:0] moved_s;
  logic                        load_s;

  function automatic logic [LANE_W-1:0] lane_move(input logic [LANE_W-1:0] x, input vrot_op_e op);
    logic [LANE_W-1:0] r;
    case (op)
      ROR:     r = (x >> SHIFT) | (x << (LANE_W - SHIFT));
      ROL:     r = (x << SHIFT) | (x >> (LANE_W - SHIFT));
      SRL:     r = x >> SHIFT;
      SLL:     r = x << SHIFT;
`ifdef VROT_ARITH_SHIFT_EN
      SRA:     r = LANE_W'($signed(x) >>> SHIFT);
`endif
      default: r = x;
    endcase
    return r;
  endfunction

  // Per-lane conditional move selected by amount bit K of that lane.
  always_comb begin
    moved_s = in_data;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (in_amt[i*AMT_W + K]) begin
        moved_s[i*LANE_W +: LANE_W] = lane_move(in_data[i*LANE_W +: LANE_W], in_op);
      end else begin
        moved_s[i*LANE_W +: LANE_W] = in_data[i*LANE_W +: LANE_W];
      end
    end
  end

  assign load_s = !valid_r || nxt_load;

  // Stage register; payload only updates on a real beat so an empty stage keeps its last data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      amt_r   <= '0;
      op_r    <= ROR;
      tag_r   <= '0;
    end else if (load_s) begin
      valid_r <= in_valid;
      if (in_valid) begin
        data_r <= moved_s;
        amt_r  <= in_amt;
        op_r   <= in_op;
        tag_r  <= in_tag;
      end
    end
  end

  assign load      = load_s;
  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_amt   = amt_r;
  assign out_op    = op_r;
  assign out_tag   = tag_r;

endmodule

// File: rtl/vrot_pipe.sv
// Pipelined per-lane rotate/shift unit: AMT_W chained vrot_stage instances.
// Build with VROT_ARITH_SHIFT_EN to add the SRA op.
module vrot_pipe
  import vrot_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 32,
  parameter int TAG_W     = 4,
  localparam int AMT_W    = vrot_amt_w(LANE_W)
) (
  input  logic  clk,
  input  logic  rst_n,
  vrot_if.slave bus
);

  localparam int DW = NUM_LANES * LANE_W;
  localparam int AW = NUM_LANES * AMT_W;

  logic [AW-1:0] amt_s;
  logic          unused_s;

  // Only the low AMT_W bits of each lane's amount field steer the shifter.
  always_comb begin
    amt_s = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      amt_s[i*AMT_W +: AMT_W] = bus.in_amt[i*LANE_W +: AMT_W];
    end
  end

  for (genvar k = 0; k < AMT_W; k++) begin : g_stg
    logic          v_in_s;
    logic [DW-1:0] d_in_s;
    logic [AW-1:0] a_in_s;
    vrot_op_e      o_in_s;
    logic [TAG_W-1:0] t_in_s;
    logic          nxt_load_s;
    logic          load_s;
    logic          v_out_s;
    logic [DW-1:0] d_out_s;
    logic [AW-1:0] a_out_s;
    vrot_op_e      o_out_s;
    logic [TAG_W-1:0] t_out_s;

    if (k == 0) begin : g_head
      assign v_in_s = bus.in_valid;
      assign d_in_s = bus.in_data;
      assign a_in_s = amt_s;
      assign o_in_s = bus.in_op;
      assign t_in_s = bus.in_tag;
    end else begin : g_body
      assign v_in_s = g_stg[k-1].v_out_s;
      assign d_in_s = g_stg[k-1].d_out_s;
      assign a_in_s = g_stg[k-1].a_out_s;
      assign o_in_s = g_stg[k-1].o_out_s;
      assign t_in_s = g_stg[k-1].t_out_s;
    end

    if (k == AMT_W - 1) begin : g_tail
      assign nxt_load_s = bus.out_ready;
    end else begin : g_link
      assign nxt_load_s = g_stg[k+1].load_s;
    end

    vrot_stage #(
      .SHIFT     (1 << k),
      .NUM_LANES (NUM_LANES),
      .LANE_W    (LANE_W),
      .TAG_W     (TAG_W)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v_in_s),
      .in_data   (d_in_s),
      .in_amt    (a_in_s),
      .in_op     (o_in_s),
      .in_tag    (t_in_s),
      .nxt_load  (nxt_load_s),
      .load      (load_s),
      .out_valid (v_out_s),
      .out_data  (d_out_s),
      .out_amt   (a_out_s),
      .out_op    (o_out_s),
      .out_tag   (t_out_s)
    );
  end

  assign bus.in_ready  = g_stg[0].load_s;
  assign bus.out_valid = g_stg[AMT_W-1].v_out_s;
  assign bus.out_data  = g_stg[AMT_W-1].d_out_s;
  assign bus.out_tag   = g_stg[AMT_W-1].t_out_s;

  // Upper amount bits and the last stage's amount/op have no consumer.
  assign unused_s = ^{bus.in_amt, g_stg[AMT_W-1].a_out_s, g_stg[AMT_W-1].o_out_s};

endmodule

// File: tb/tb_vrot_pipe.sv
// Scoreboard bench for vrot_pipe: directed vectors, backpressure, stall and reset-in-flight.
module tb_vrot_pipe;
  import vrot_pkg::*;

  localparam int NL = 4;
  localparam int LW = 32;
  localparam int TW = 4;
  localparam int AW = 5;
  localparam int DW = NL * LW;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vrot_if #(.NUM_LANES(NL), .LANE_W(LW), .TAG_W(TW)) bus ();

  vrot_pipe #(.NUM_LANES(NL), .LANE_W(LW), .TAG_W(TW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            n_out = 0;
  int            rdy_mode = 1;
  logic          stall_seen = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic [TW-1:0] hold_tag = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference: bit-by-bit lane model, independent of the staged shifter.
  function automatic logic [DW-1:0] model(input vrot_beat_t b);
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < NL; l++) begin
      logic [LW-1:0] x;
      int a;
      x = b.data[l*LW +: LW];
      a = int'(b.amt[l*LW +: AW]);
      for (int i = 0; i < LW; i++) begin
        case (b.op)
          ROR: r[l*LW + i] = x[(i + a) % LW];
          ROL: r[l*LW + i] = x[(i - a + LW) % LW];
          SRL: r[l*LW + i] = (i + a < LW) ? x[i + a] : 1'b0;
          SLL: r[l*LW + i] = (i >= a) ? x[i - a] : 1'b0;
`ifdef VROT_ARITH_SHIFT_EN
          SRA: r[l*LW + i] = (i + a < LW) ? x[i + a] : x[LW-1];
`endif
          default: r[l*LW + i] = x[i];
        endcase
      end
    end
    return r;
  endfunction

  function automatic vrot_beat_t mk(input logic [LW-1:0] d3, d2, d1, d0,
                                    input logic [LW-1:0] a3, a2, a1, a0,
                                    input vrot_op_e op, input logic [TW-1:0] tag);
    vrot_beat_t b;
    b.data = {d3, d2, d1, d0};
    b.amt  = {a3, a2, a1, a0};
    b.op   = op;
    b.tag  = tag;
    return b;
  endfunction

  function automatic vrot_beat_t bulk(input int i);
    vrot_beat_t b;
    for (int l = 0; l < NL; l++) begin
      b.data[l*LW +: LW] = 32'h9E37_79B9 * (i * 4 + l + 1);
      b.amt[l*LW +: LW]  = 32'((i * 7 + l * 5) % 32);
    end
    b.op  = vrot_op_e'(i % 4);
    b.tag = TW'(i);
    return b;
  endfunction

  // Monitor: pops on every transfer and checks stability while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_seen <= 1'b0;
    end else begin
      if (stall_seen) begin
        chk("hold_valid", DW'(bus.out_valid), DW'(1'b1));
        chk("hold_data", bus.out_data, hold_data);
        chk("hold_tag", DW'(bus.out_tag), DW'(hold_tag));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got beat tag %0d data %h, required no beat", bus.out_tag, bus.out_data);
        end else begin
          chk("out_data", bus.out_data, exp_q[0].data);
          chk("out_tag", DW'(bus.out_tag), DW'(exp_q[0].tag));
          void'(exp_q.pop_front());
        end
        n_out <= n_out + 1;
      end
      stall_seen <= bus.out_valid && !bus.out_ready;
      hold_data  <= bus.out_data;
      hold_tag   <= bus.out_tag;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b0;
      2:       bus.out_ready = ~bus.out_ready;
      default: bus.out_ready = 1'b1;
    endcase
  endtask

  task automatic send(input vrot_beat_t b, input logic [DW-1:0] exp_data);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b.data;
    bus.in_amt   = b.amt;
    bus.in_op    = b.op;
    bus.in_tag   = b.tag;
    #1;
    while (!bus.in_ready && guard < 64) begin
      tick();
      #1;
      guard++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: tag %0d in_ready stayed 0, required 1", b.tag);
    end else begin
      exp_q.push_back('{data: exp_data, tag: b.tag});
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      tick();
      g++;
    end
    chk("drain", DW'(exp_q.size()), DW'(0));
  endtask

  initial begin
    vrot_beat_t b;
    int lat;
    int acc;
    int n0;
    int w;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_op     = ROR;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", DW'(bus.out_valid), DW'(1'b0));
    chk("rst_in_ready", DW'(bus.in_ready), DW'(1'b1));
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_out_tag", DW'(bus.out_tag), DW'(0));
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // ROR by 1 on lane 0, other lanes pass; also measures latency.
    b = mk(32'h1234_5678, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h0000_0001,
           32'd0, 32'd0, 32'd0, 32'd1, ROR, 4'd1);
    send(b, {32'h1234_5678, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h8000_0000});
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", DW'(lat), DW'(AW));
    drain();

    b = mk(32'h0000_0000, 32'hFFFF_0000, 32'h1234_5678, 32'h8000_0001,
           32'd31, 32'd16, 32'd8, 32'd1, ROL, 4'd2);
    send(b, {32'h0000_0000, 32'h0000_FFFF, 32'h3456_7812, 32'h0000_0003});
    b = mk(32'hF000_000F, 32'hF000_000F, 32'hF000_000F, 32'hF000_000F,
           32'd4, 32'd4, 32'd4, 32'd4, SRL, 4'd3);
    send(b, {4{32'h0F00_0000}});
    b = mk(32'hF000_000F, 32'hF000_000F, 32'hF000_000F, 32'hF000_000F,
           32'd4, 32'd4, 32'd4, 32'd4, SLL, 4'd4);
    send(b, {4{32'h0000_00F0}});
    // Maximum amount and ignored upper amount bits.
    b = mk(32'h0000_FFFF, 32'hA5A5_A5A5, 32'h8000_0000, 32'h0000_0001,
           32'd16, 32'hFFFF_FFE0, 32'd31, 32'h0000_011F, ROR, 4'd5);
    send(b, {32'hFFFF_0000, 32'hA5A5_A5A5, 32'h0000_0001, 32'h0000_0002});
    b = mk(32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd31, 32'd31, 32'd0, 32'd31, SRL, 4'd6);
    send(b, {32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'h0000_0001});
`ifdef VROT_ARITH_SHIFT_EN
    b = mk(32'h7000_0000, 32'h4000_0000, 32'h8000_0000, 32'h8000_0000,
           32'd31, 32'd4, 32'd4, 32'd31, SRA, 4'd7);
    send(b, {32'h0000_0000, 32'h0400_0000, 32'hF800_0000, 32'hFFFF_FFFF});
`endif
    drain();

    // Back-to-back beats with out_ready toggling every cycle.
    rdy_mode = 2;
    for (int i = 0; i < 10; i++) begin
      b = bulk(i);
      send(b, model(b));
    end
    rdy_mode = 1;
    drain();

    // Full stall: only AMT_W beats fit, then 1 beat/cycle on release.
    rdy_mode = 0;
    tick();
    acc = 0;
    for (int j = 0; j < 8; j++) begin
      b = bulk(20 + j);
      bus.in_valid = 1'b1;
      bus.in_data  = b.data;
      bus.in_amt   = b.amt;
      bus.in_op    = b.op;
      bus.in_tag   = b.tag;
      #1;
      if (bus.in_ready) begin
        exp_q.push_back('{data: model(b), tag: b.tag});
        acc++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("stall_accepted", DW'(acc), DW'(AW));
    chk("stall_in_ready", DW'(bus.in_ready), DW'(1'b0));
    rdy_mode = 1;
    tick();
    #1;
    chk("full_pass_in_ready", DW'(bus.in_ready), DW'(1'b1));
    n0 = n_out;
    repeat (5) tick();
    chk("release_rate", DW'(n_out - n0), DW'(5));
    chk("release_empty", DW'(bus.out_valid), DW'(1'b0));
    drain();

    // Reset with three beats in flight.
    rdy_mode = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      b = bulk(40 + i);
      send(b, model(b));
    end
    w = 0;
    while (!bus.out_valid && w < 20) begin
      tick();
      w++;
    end
    chk("rst_fill", DW'(bus.out_valid), DW'(1'b1));
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_async_valid", DW'(bus.out_valid), DW'(1'b0));
    chk("rst_async_in_ready", DW'(bus.in_ready), DW'(1'b1));
    chk("rst_async_data", bus.out_data, '0);
    repeat (2) tick();
    rst_n = 1'b1;
    rdy_mode = 1;
    n0 = n_out;
    repeat (12) tick();
    chk("rst_no_output", DW'(n_out - n0), DW'(0));

    // Pipe still works after the flush.
    b = bulk(7);
    send(b, model(b));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
